// File: rtl/pe_array_feeder_if.sv
// Weight-row and activation-vector valid/ready streams into the PE array feeder.
// The master modport is the upstream source; the slave modport is the feeder.
interface pe_array_feeder_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8
);
    logic                       w_valid;
    logic                       w_ready;
    logic [COLS*DATA_WIDTH-1:0] w_data;
    logic                       a_valid;
    logic                       a_ready;
    logic [ROWS*DATA_WIDTH-1:0] a_data;
    logic                       a_last;

    modport master (
        output w_valid, w_data, a_valid, a_data, a_last,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, a_last,
        output w_ready, a_ready
    );
endinterface

// File: rtl/pe_array_feeder.sv
// Input sequencer for the weight-stationary systolic array: loads weight rows one per beat,
// then streams activation vectors with a per-row skew, drains with zeros and pulses done.
module pe_array_feeder #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    pe_array_feeder_if.slave           bus,
    output logic [ROWS-1:0]            arr_load_weight,
    output logic [COLS*DATA_WIDTH-1:0] arr_weight,
    output logic                       arr_en_compute,
    output logic [ROWS*DATA_WIDTH-1:0] arr_act,
    output logic [ROWS-1:0]            arr_act_vld,
    output logic                       busy,
    output logic                       done
);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_CYC = ROWS + COLS - 1;
    localparam int CW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t                             state, state_nxt;
    logic   [RW-1:0]                    row_cnt;
    logic   [CW-1:0]                    drain_cnt;
    logic                               w_acc, a_acc;
    logic   [ROWS-1:0][DATA_WIDTH-1:0]  lane_in;

    assign w_acc = bus.w_valid && (state == LOAD_W);
    assign a_acc = bus.a_valid && (state == STREAM);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.w_ready = 1'b0;
        bus.a_ready = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD_W;
            LOAD_W: begin
                bus.w_ready = 1'b1;
                if (w_acc && row_cnt == LAST_ROW) state_nxt = STREAM;
            end
            STREAM: begin
                bus.a_ready = 1'b1;
                if (a_acc && bus.a_last) state_nxt = DRAIN;
            end
            DRAIN:  if (drain_cnt == LAST_DRAIN) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt         <= '0;
            drain_cnt       <= '0;
            arr_load_weight <= '0;
            arr_weight      <= '0;
            arr_en_compute  <= 1'b0;
        end else begin
            // Compute enable covers exactly the STREAM and DRAIN cycles.
            arr_en_compute  <= (state_nxt == STREAM) || (state_nxt == DRAIN);
            arr_load_weight <= '0;
            if (state == IDLE && start) row_cnt <= '0;
            if (w_acc) begin
                arr_load_weight <= ROWS'(1) << row_cnt;
                arr_weight      <= bus.w_data;
                row_cnt         <= row_cnt + RW'(1);
            end
            if (a_acc && bus.a_last) drain_cnt <= '0;
            else if (state == DRAIN) drain_cnt <= drain_cnt + CW'(1);
        end
    end

    // Non-accept cycles inject zero bubbles so the array sees clean zeros.
    assign lane_in = a_acc ? bus.a_data : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        // Lane r: r skew registers plus the output register, r+1 stages in total.
        logic [r:0][DATA_WIDTH-1:0] data_pipe;
        logic [r:0]                 vld_pipe;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_pipe <= '0;
                vld_pipe  <= '0;
            end else begin
                data_pipe[0] <= lane_in[r];
                vld_pipe[0]  <= a_acc;
                for (int i = 1; i <= r; i++) begin
                    data_pipe[i] <= data_pipe[i-1];
                    vld_pipe[i]  <= vld_pipe[i-1];
                end
            end
        end

        assign arr_act[r*DATA_WIDTH +: DATA_WIDTH] = data_pipe[r];
        assign arr_act_vld[r]                      = vld_pipe[r];
    end
endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: directed scenarios plus randomized traffic, all checked
// against a job-level reference model that tracks phases and accepted vectors by cycle.
module tb_pe_array_feeder;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int OW   = 5 + ROWS + COLS*DW + ROWS*DW + ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [ROWS-1:0]      arr_load_weight;
    logic [COLS*DW-1:0]   arr_weight;
    logic                 arr_en_compute;
    logic [ROWS*DW-1:0]   arr_act;
    logic [ROWS-1:0]      arr_act_vld;
    logic                 busy, done;
    logic [OW-1:0]        obs;

    pe_array_feeder_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) bus ();

    pe_array_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .arr_load_weight(arr_load_weight), .arr_weight(arr_weight),
        .arr_en_compute(arr_en_compute), .arr_act(arr_act), .arr_act_vld(arr_act_vld),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {bus.w_ready, bus.a_ready, busy, done, arr_en_compute,
                  arr_load_weight, arr_weight, arr_act, arr_act_vld};

    int ncmp = 0;
    int nfail = 0;

    // Reference model: phase 0 idle, 1 load, 2 stream, 3 drain, 4 done.
    int                 ph = 0, rowi = 0, dleft = 0, t = 0;
    logic [ROWS-1:0]    m_lw = '0;
    logic [COLS*DW-1:0] m_w = '0;
    logic [ROWS*DW-1:0] inj_d [int];   // accepted vectors keyed by the cycle they were taken

    function automatic logic [OW-1:0] expv();
        logic [ROWS*DW-1:0] act = '0;
        logic [ROWS-1:0]    vld = '0;
        logic [ROWS*DW-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            int k = t - 1 - r;
            if (inj_d.exists(k)) begin
                v = inj_d[k];
                act[r*DW +: DW] = v[r*DW +: DW];
                vld[r] = 1'b1;
            end
        end
        return {ph == 1, ph == 2, ph != 0, ph == 4, (ph == 2) || (ph == 3), m_lw, m_w, act, vld};
    endfunction

    task automatic tick();
        bit wa, aa;
        if (rst) begin
            ph = 0; rowi = 0; dleft = 0; m_lw = '0; m_w = '0;
            inj_d.delete();
        end else begin
            wa = (ph == 1) && bus.w_valid;
            aa = (ph == 2) && bus.a_valid;
            m_lw = '0;
            if (wa) begin m_lw[rowi] = 1'b1; m_w = bus.w_data; end
            if (aa) inj_d[t] = bus.a_data;
            case (ph)
                0: if (start) begin ph = 1; rowi = 0; end
                1: if (wa) begin if (rowi == ROWS-1) ph = 2; else rowi++; end
                2: if (aa && bus.a_last) begin ph = 3; dleft = ROWS + COLS - 1; end
                3: begin dleft--; if (dleft == 0) ph = 4; end
                default: ph = 0;
            endcase
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        start = 1'b0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.a_last = 1'b0;
    endtask

    // Stimulus only: start a job and load ROWS random weight rows back-to-back.
    task automatic load_job();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
            bus.w_valid = 1'b1; bus.w_data = $urandom; tick();
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1; start = 1'b1;
        tick(); tick();
        ncmp++; if (obs !== '0) begin nfail++; $display("FAIL reset_outputs: got %h want 0", obs); end
        rst = 1'b0; start = 1'b0;
        tick();
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_start_ignored: busy got %b want 0", busy); end
        ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL reset_model: got %h want %h", obs, expv()); end
    endtask

    task automatic test_weight_load();
        logic [31:0] beats [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        logic [3:0]  one = 4'b0001;
        logic [3:0]  exp_lw;
        int b = 0;
        start = 1'b1; tick(); start = 1'b0;
        ncmp++; if (bus.w_ready !== 1'b1) begin nfail++; $display("FAIL wl_ready: got %b want 1", bus.w_ready); end
        for (int s = 0; s < 5; s++) begin
            bus.w_valid = (s != 2);
            bus.w_data  = (s != 2) ? beats[b] : 32'hDEADBEEF;
            tick();
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL wl_model s=%0d: got %h want %h", s, obs, expv()); end
            exp_lw = (s == 2) ? 4'b0000 : (one << b);
            ncmp++; if (arr_load_weight !== exp_lw) begin nfail++; $display("FAIL wl_strobe s=%0d: got %b want %b", s, arr_load_weight, exp_lw); end
            if (s != 2) begin
                ncmp++; if (arr_weight !== beats[b]) begin nfail++; $display("FAIL wl_weight s=%0d: got %h want %h", s, arr_weight, beats[b]); end
                b++;
            end
        end
        bus.w_valid = 1'b0;
        ncmp++; if (bus.w_ready !== 1'b0) begin nfail++; $display("FAIL wl_ready_fall: got %b want 0", bus.w_ready); end
    endtask

    task automatic test_skew();
        logic [ROWS-1:0][DW-1:0] v0, v1;
        logic [ROWS*DW-1:0] cap_act [1:6];
        logic [ROWS-1:0]    cap_vld [1:6];
        logic [DW-1:0] ed;
        logic ev;
        v0 = {8'd4, 8'd3, 8'd2, 8'd1};
        v1 = {8'd8, 8'd7, 8'd6, 8'd5};
        for (int k = 1; k <= 6; k++) begin
            bus.a_valid = (k <= 2);
            bus.a_data  = (k == 1) ? v0 : (k == 2) ? v1 : '0;
            bus.a_last  = (k == 2);
            tick();
            cap_act[k] = arr_act; cap_vld[k] = arr_act_vld;
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL skew_model k=%0d: got %h want %h", k, obs, expv()); end
        end
        quiet_inputs();
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 1; k <= 6; k++) begin
                ev = (k == r + 1) || (k == r + 2);
                ed = (k == r + 1) ? v0[r] : (k == r + 2) ? v1[r] : 8'h00;
                ncmp++; if (cap_vld[k][r] !== ev) begin nfail++; $display("FAIL skew_vld r=%0d k=%0d: got %b want %b", r, k, cap_vld[k][r], ev); end
                ncmp++; if (cap_act[k][r*DW +: DW] !== ed) begin nfail++; $display("FAIL skew_data r=%0d k=%0d: got %h want %h", r, k, cap_act[k][r*DW +: DW], ed); end
            end
        end
        for (int i = 0; i < 20 && ph != 0; i++) begin
            tick();
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL skew_drain_model: got %h want %h", obs, expv()); end
        end
    endtask

    task automatic test_bubble_sign();
        logic [DW-1:0] l1 [1:5];
        logic          v1 [1:5];
        logic          en [1:5];
        load_job();
        for (int k = 1; k <= 5; k++) begin
            bus.a_valid = (k == 1) || (k == 3);
            bus.a_data  = (k == 1) ? 32'h0000FD00 : (k == 3) ? 32'h00000700 : 32'h0;
            bus.a_last  = (k == 3);
            tick();
            l1[k] = arr_act[DW +: DW]; v1[k] = arr_act_vld[1]; en[k] = arr_en_compute;
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL bubble_model k=%0d: got %h want %h", k, obs, expv()); end
        end
        quiet_inputs();
        ncmp++; if (l1[2] !== 8'hFD || v1[2] !== 1'b1) begin nfail++; $display("FAIL bubble_neg: got %h/%b want fd/1", l1[2], v1[2]); end
        ncmp++; if (l1[3] !== 8'h00 || v1[3] !== 1'b0) begin nfail++; $display("FAIL bubble_gap: got %h/%b want 00/0", l1[3], v1[3]); end
        ncmp++; if (l1[4] !== 8'h07 || v1[4] !== 1'b1) begin nfail++; $display("FAIL bubble_pos: got %h/%b want 07/1", l1[4], v1[4]); end
        for (int k = 1; k <= 5; k++) begin
            ncmp++; if (en[k] !== 1'b1) begin nfail++; $display("FAIL bubble_en k=%0d: got %b want 1", k, en[k]); end
        end
        for (int i = 0; i < 20 && ph != 0; i++) tick();
    endtask

    task automatic test_drain_done();
        int n = 0;
        load_job();
        for (int i = 0; i < 4; i++) begin
            bus.a_valid = 1'b1; bus.a_data = $urandom;
            bus.a_last  = (i == 3);
            start       = (i == 1);
            tick();
            start = 1'b0;
            if (i < 3) begin
                ncmp++; if (bus.a_ready !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL dd_stream i=%0d: a_ready %b busy %b want 1 1", i, bus.a_ready, busy); end
            end
        end
        quiet_inputs();
        while (arr_en_compute === 1'b1 && n < 20) begin
            n++;
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL dd_model n=%0d: got %h want %h", n, obs, expv()); end
            tick();
        end
        ncmp++; if (n != ROWS + COLS - 1) begin nfail++; $display("FAIL dd_len: got %0d want %0d", n, ROWS + COLS - 1); end
        ncmp++; if (done !== 1'b1) begin nfail++; $display("FAIL dd_done: got %b want 1", done); end
        tick();
        ncmp++; if (done !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL dd_idle: done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        load_job();
        bus.a_valid = 1'b1; bus.a_data = $urandom | 32'h01000000; tick();
        bus.a_valid = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        ncmp++; if (obs !== '0) begin nfail++; $display("FAIL abort_clear: got %h want 0", obs); end
        ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL abort_model: got %h want %h", obs, expv()); end
        for (int i = 0; i < 8; i++) begin
            tick();
            ncmp++; if (obs !== '0) begin nfail++; $display("FAIL abort_quiet i=%0d: got %h want 0", i, obs); end
        end
        load_job();
        for (int i = 0; i < 2; i++) begin
            bus.a_valid = 1'b1; bus.a_data = $urandom; bus.a_last = (i == 1); tick();
        end
        quiet_inputs();
        for (int i = 0; i < 20 && !seen; i++) begin
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL abort_rejob_model: got %h want %h", obs, expv()); end
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        ncmp++; if (!seen) begin nfail++; $display("FAIL abort_rejob_done: got 0 want 1 within 20 cycles"); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 5) == 0);
            bus.w_valid = $urandom_range(0, 1) == 1;
            bus.w_data  = $urandom;
            bus.a_valid = $urandom_range(0, 3) != 0;
            bus.a_data  = $urandom;
            bus.a_last  = ($urandom_range(0, 7) == 0);
            tick();
            ncmp++; if (obs !== expv()) begin nfail++; $display("FAIL random i=%0d: got %h want %h", i, obs, expv()); end
        end
        rst = 1'b0;
        quiet_inputs();
    endtask

    initial begin
        quiet_inputs();
        test_reset();
        test_weight_load();
        test_skew();
        test_bubble_sign();
        test_drain_done();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
